decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : LEGv8 instruction decode stage. 32 x XLEN register file with
//               write-through bypass, instruction decode, immediate generation,
//               load-use hazard detection and ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetl,
  input  logic [31:0]     instruction_ID,
  input  logic [XLEN-1:0] pc_ID,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            branch_taken_MEM,
  output logic            pc_stall,
  output logic [XLEN-1:0] pc_EX,
  output logic [XLEN-1:0] rdata1_EX,
  output logic [XLEN-1:0] rdata2_EX,
  output logic [XLEN-1:0] imm_EX,
  output logic [4:0]      rd_EX,
  output logic [4:0]      rn_EX,
  output logic [4:0]      rm_EX,
  output logic            valid_EX,
  output logic            regwrite_EX,
  output logic            memread_EX,
  output logic            memwrite_EX,
  output logic            mem2reg_EX,
  output logic            alusrc_EX,
  output logic            branch_EX,
  output logic            uncond_EX,
  output logic [1:0]      aluop_EX
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [4:0]  XZR     = 5'd31;

  logic [XLEN-1:0] regs [32];

  logic            is_r, is_ldur, is_stur, is_addi, is_cbz, is_b;
  logic [4:0]      rn, rm, rd;
  logic            uses_rn, uses_rm;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic            regwrite, memread, memwrite, mem2reg, alusrc, branch, uncond;
  logic [1:0]      aluop;
  logic            hazard, bubble;

  // Opcode classification, register indices, immediate and control decode
  always_comb begin
    is_r    = (instruction_ID[31:21] == OP_ADD) || (instruction_ID[31:21] == OP_SUB) ||
              (instruction_ID[31:21] == OP_AND) || (instruction_ID[31:21] == OP_ORR);
    is_ldur = (instruction_ID[31:21] == OP_LDUR);
    is_stur = (instruction_ID[31:21] == OP_STUR);
    is_addi = (instruction_ID[31:22] == OP_ADDI);
    is_cbz  = (instruction_ID[31:24] == OP_CBZ);
    is_b    = (instruction_ID[31:26] == OP_B);

    rn      = instruction_ID[9:5];
    rd      = instruction_ID[4:0];
    // Port 2 reads Rm for R-type, otherwise Rt (STUR data / CBZ test value)
    rm      = is_r ? instruction_ID[20:16] : instruction_ID[4:0];
    uses_rn = is_r || is_ldur || is_stur || is_addi;
    uses_rm = is_r || is_stur || is_cbz;

    imm      = '0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    uncond   = 1'b0;
    aluop    = 2'b00;

    if (is_r) begin
      regwrite = 1'b1;
      aluop    = 2'b10;
    end else if (is_ldur || is_stur) begin
      imm      = {{(XLEN-9){instruction_ID[20]}}, instruction_ID[20:12]};
      regwrite = is_ldur;
      memread  = is_ldur;
      mem2reg  = is_ldur;
      memwrite = is_stur;
      alusrc   = 1'b1;
    end else if (is_addi) begin
      imm      = {{(XLEN-12){1'b0}}, instruction_ID[21:10]};
      regwrite = 1'b1;
      alusrc   = 1'b1;
    end else if (is_cbz) begin
      imm      = {{(XLEN-21){instruction_ID[23]}}, instruction_ID[23:5], 2'b00};
      branch   = 1'b1;
      aluop    = 2'b01;
    end else if (is_b) begin
      imm      = {{(XLEN-28){instruction_ID[25]}}, instruction_ID[25:0], 2'b00};
      uncond   = 1'b1;
    end
  end

  // Register read ports: XZR reads zero, a same-cycle writeback is forwarded
  always_comb begin
    if (rn == XZR)                       rdata1 = '0;
    else if (wb_regwrite && wb_rd == rn) rdata1 = wb_data;
    else                                 rdata1 = regs[rn];

    if (rm == XZR)                       rdata2 = '0;
    else if (wb_regwrite && wb_rd == rm) rdata2 = wb_data;
    else                                 rdata2 = regs[rm];
  end

  // Load-use hazard against the load now in EX; a redirect squashes the stall
  always_comb begin
    hazard   = memread_EX && (rd_EX != XZR) &&
               ((uses_rn && (rn == rd_EX)) || (uses_rm && (rm == rd_EX)));
    pc_stall = hazard && !branch_taken_MEM;
    bubble   = hazard || branch_taken_MEM;
  end

  // Register file write port; XZR is never written
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_regwrite && (wb_rd != XZR)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX pipeline register; stall or flush inserts a bubble (controls cleared)
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      pc_EX       <= '0;
      rdata1_EX   <= '0;
      rdata2_EX   <= '0;
      imm_EX      <= '0;
      rd_EX       <= '0;
      rn_EX       <= '0;
      rm_EX       <= '0;
      valid_EX    <= 1'b0;
      regwrite_EX <= 1'b0;
      memread_EX  <= 1'b0;
      memwrite_EX <= 1'b0;
      mem2reg_EX  <= 1'b0;
      alusrc_EX   <= 1'b0;
      branch_EX   <= 1'b0;
      uncond_EX   <= 1'b0;
      aluop_EX    <= 2'b00;
    end else begin
      pc_EX       <= pc_ID;
      rdata1_EX   <= rdata1;
      rdata2_EX   <= rdata2;
      imm_EX      <= imm;
      rd_EX       <= rd;
      rn_EX       <= rn;
      rm_EX       <= rm;
      valid_EX    <= !bubble;
      regwrite_EX <= regwrite && !bubble;
      memread_EX  <= memread  && !bubble;
      memwrite_EX <= memwrite && !bubble;
      mem2reg_EX  <= mem2reg  && !bubble;
      alusrc_EX   <= alusrc   && !bubble;
      branch_EX   <= branch   && !bubble;
      uncond_EX   <= uncond   && !bubble;
      aluop_EX    <= bubble ? 2'b00 : aluop;
    end
  end

endmodule
`default_nettype wire
